// File: rtl/alu_seq.sv
// Registered ALU with status flags, add-with-carry and a multi-cycle shift-add multiply.
// Single-cycle ops complete at the accept edge; MUL takes WIDTH further cycles.
module alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic {
        StIdle,
        StMul
    } state_e;

    state_e               state_q;
    logic [WIDTH-1:0]     result_q;
    logic [3:0]           flags_q;
    logic                 done_q;
    logic [2*WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]     b_q;
    logic [2*WIDTH-1:0]   prod_q;
    logic [CntW-1:0]      cnt_q;

    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_c;
    logic                 alu_v;
    logic [2*WIDTH-1:0]   prod_d;
    logic                 mul_hi_nz;

    // Single-cycle datapath; the carry comes from the (WIDTH+1)-bit sum.
    always_comb begin
        sum     = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        unique case (opcode)
            3'b000: alu_res = operandA & operandB;
            3'b001: alu_res = operandA | operandB;
            3'b010: alu_res = ~(operandA & operandB);
            3'b011: alu_res = ~(operandA | operandB);
            3'b100, 3'b110: begin
                sum = {1'b0, operandA} + {1'b0, operandB}
                    + {{WIDTH{1'b0}}, (opcode == 3'b110) & flags_q[3]};
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (operandA[WIDTH-1] == operandB[WIDTH-1])
                       && (alu_res[WIDTH-1] != operandA[WIDTH-1]);
            end
            3'b101: begin
                // C reports borrow, the inverse of the adder carry.
                sum     = {1'b0, operandA} + {1'b0, ~operandB} + {{WIDTH{1'b0}}, 1'b1};
                alu_res = sum[WIDTH-1:0];
                alu_c   = ~sum[WIDTH];
                alu_v   = (operandA[WIDTH-1] != operandB[WIDTH-1])
                       && (alu_res[WIDTH-1] != operandA[WIDTH-1]);
            end
            default: alu_res = '0;
        endcase
    end

    assign prod_d    = prod_q + (b_q[0] ? a_q : '0);
    assign mul_hi_nz = |prod_d[2*WIDTH-1:WIDTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            result_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (opcode == 3'b111) begin
                            a_q     <= {{WIDTH{1'b0}}, operandA};
                            b_q     <= operandB;
                            prod_q  <= '0;
                            cnt_q   <= CntW'(WIDTH);
                            state_q <= StMul;
                        end else begin
                            result_q <= alu_res;
                            flags_q  <= {alu_c, alu_v, alu_res[WIDTH-1], alu_res == '0};
                            done_q   <= 1'b1;
                        end
                    end
                end
                StMul: begin
                    prod_q <= prod_d;
                    a_q    <= a_q << 1;
                    b_q    <= b_q >> 1;
                    cnt_q  <= cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        result_q <= prod_d[WIDTH-1:0];
                        flags_q  <= {mul_hi_nz, mul_hi_nz, prod_d[WIDTH-1],
                                     prod_d[WIDTH-1:0] == '0};
                        done_q   <= 1'b1;
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign result = result_q;
    assign flags  = flags_q;
    assign done   = done_q;
    assign busy   = (state_q == StMul);

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: 8-bit instance for most scenarios, 16-bit instance for MUL width.
module tb_alu_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  opcode;
    logic [7:0]  operandA, operandB, result;
    logic [3:0]  flags;
    logic        busy, done;

    logic        start16;
    logic [15:0] a16, b16, result16;
    logic [3:0]  flags16;
    logic        busy16, done16;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    alu_seq #(.WIDTH(8)) dut (
        .clock(clock), .reset(reset), .start(start), .opcode(opcode),
        .operandA(operandA), .operandB(operandB), .result(result),
        .flags(flags), .busy(busy), .done(done)
    );

    alu_seq #(.WIDTH(16)) dut16 (
        .clock(clock), .reset(reset), .start(start16), .opcode(3'b111),
        .operandA(a16), .operandB(b16), .result(result16),
        .flags(flags16), .busy(busy16), .done(done16)
    );

    // Drive one start at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        start = 1'b1; opcode = op; operandA = a; operandB = b;
        @(posedge clock); @(negedge clock);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if ({result, flags, busy, done} !== 14'h0) begin
            failures++;
            $display("FAIL reset_state got res=%h flags=%b busy=%b done=%b want 00/0000/0/0",
                     result, flags, busy, done);
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_logic();
        logic [7:0] exp_res [4] = '{8'h05, 8'h5F, 8'hFA, 8'hA0};
        logic [3:0] exp_flg [4] = '{4'b0000, 4'b0000, 4'b0010, 4'b0010};
        for (int i = 0; i < 4; i++) begin
            issue(3'(i), 8'h0F, 8'h55);
            checks++;
            if ({done, result, flags} !== {1'b1, exp_res[i], exp_flg[i]}) begin
                failures++;
                $display("FAIL logic_op%0d got done=%b res=%h flags=%b want 1/%h/%b",
                         i, done, result, flags, exp_res[i], exp_flg[i]);
            end
            @(negedge clock);
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL logic_done_pulse%0d got done=%b want 0", i, done);
            end
        end
    endtask

    task automatic test_addsub();
        logic [2:0] ops [3] = '{3'b100, 3'b101, 3'b101};
        logic [7:0] as  [3] = '{8'hFF, 8'h00, 8'h80};
        logic [7:0] bs  [3] = '{8'h55, 8'h55, 8'h01};
        logic [7:0] er  [3] = '{8'h54, 8'hAB, 8'h7F};
        logic [3:0] ef  [3] = '{4'b1000, 4'b1010, 4'b0100};
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], as[i], bs[i]);
            checks++;
            if ({done, result, flags} !== {1'b1, er[i], ef[i]}) begin
                failures++;
                $display("FAIL addsub%0d got done=%b res=%h flags=%b want 1/%h/%b",
                         i, done, result, flags, er[i], ef[i]);
            end
        end
    endtask

    task automatic test_carry_chain();
        logic [2:0] ops [3] = '{3'b100, 3'b110, 3'b110};
        logic [7:0] as  [3] = '{8'hFF, 8'h00, 8'h00};
        logic [7:0] bs  [3] = '{8'h01, 8'h00, 8'h00};
        logic [7:0] er  [3] = '{8'h00, 8'h01, 8'h00};
        logic [3:0] ef  [3] = '{4'b1001, 4'b0000, 4'b0001};
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], as[i], bs[i]);
            checks++;
            if ({done, result, flags} !== {1'b1, er[i], ef[i]}) begin
                failures++;
                $display("FAIL carry%0d got done=%b res=%h flags=%b want 1/%h/%b",
                         i, done, result, flags, er[i], ef[i]);
            end
        end
    endtask

    task automatic test_mul();
        int busy_cycles = 0;
        issue(3'b111, 8'h0F, 8'h11);
        for (int n = 0; n < 8; n++) begin
            if (n > 0) begin
                @(posedge clock); @(negedge clock);
                if (n == 4) start = 1'b0;
            end
            if (busy) busy_cycles++;
            checks++;
            if ({busy, done} !== 2'b10) begin
                failures++;
                $display("FAIL mul_busy_n%0d got busy=%b done=%b want 1/0", n, busy, done);
            end
            // Ignored ADD, sampled at accept+4 while busy.
            if (n == 3) begin
                start = 1'b1; opcode = 3'b100; operandA = 8'h01; operandB = 8'h01;
            end
        end
        @(posedge clock); @(negedge clock);
        checks++;
        if ({busy, done, result, flags} !== {2'b01, 8'hFF, 4'b0010}) begin
            failures++;
            $display("FAIL mul_result got busy=%b done=%b res=%h flags=%b want 0/1/ff/0010",
                     busy, done, result, flags);
        end
        checks++;
        if (busy_cycles != 8) begin
            failures++;
            $display("FAIL mul_busy_len got %0d want 8", busy_cycles);
        end
        @(negedge clock);
        checks++;
        if ({busy, done, result} !== {2'b00, 8'hFF}) begin
            failures++;
            $display("FAIL mul_after got busy=%b done=%b res=%h want 0/0/ff", busy, done, result);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        issue(3'b111, 8'h10, 8'h10);
        while (!done && n < 20) begin
            @(posedge clock); @(negedge clock);
            n++;
        end
        checks++;
        if (n != 8 || {result, flags} !== {8'h00, 4'b1101}) begin
            failures++;
            $display("FAIL mul_ovf got lat=%0d res=%h flags=%b want 8/00/1101", n, result, flags);
        end
        issue(3'b100, 8'h01, 8'h01);
        checks++;
        if ({done, result, flags} !== {1'b1, 8'h02, 4'b0000}) begin
            failures++;
            $display("FAIL b2b_add got done=%b res=%h flags=%b want 1/02/0000",
                     done, result, flags);
        end
    endtask

    task automatic test_reset_mid_mul();
        int done_seen = 0;
        issue(3'b111, 8'h0F, 8'h11);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(posedge clock); @(negedge clock);
        reset = 1'b0;
        checks++;
        if ({result, flags, busy, done} !== 14'h0) begin
            failures++;
            $display("FAIL reset_mid_mul got res=%h flags=%b busy=%b done=%b want 00/0000/0/0",
                     result, flags, busy, done);
        end
        repeat (10) begin
            @(negedge clock);
            if (done || busy) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            failures++;
            $display("FAIL reset_discard got %0d busy/done cycles want 0", done_seen);
        end
        issue(3'b100, 8'h02, 8'h03);
        checks++;
        if ({done, result, flags} !== {1'b1, 8'h05, 4'b0000}) begin
            failures++;
            $display("FAIL post_reset_add got done=%b res=%h flags=%b want 1/05/0000",
                     done, result, flags);
        end
    endtask

    task automatic test_width16();
        int n = 0;
        start16 = 1'b1; a16 = 16'h00FF; b16 = 16'h0101;
        @(posedge clock); @(negedge clock);
        start16 = 1'b0;
        while (!done16 && n < 40) begin
            @(posedge clock); @(negedge clock);
            n++;
        end
        checks++;
        if (n != 16 || {busy16, result16, flags16} !== {1'b0, 16'hFFFF, 4'b0010}) begin
            failures++;
            $display("FAIL mul16 got lat=%0d busy=%b res=%h flags=%b want 16/0/ffff/0010",
                     n, busy16, result16, flags16);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; opcode = 3'b000; operandA = '0; operandB = '0;
        start16 = 1'b0; a16 = '0; b16 = '0;
        @(negedge clock);
        test_reset();
        test_logic();
        test_addsub();
        test_carry_chain();
        test_mul();
        test_back_to_back();
        test_reset_mid_mul();
        test_width16();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
